// File: rtl/ysyx_22040750_ifu_queue.sv
// Instruction fetch stage: issues sequential fetches, queues in-order responses with their PCs,
// and squashes responses of flushed requests. Define YSYX_22040750_IFU_PERF_EN to add perf counters.
module ysyx_22040750_ifu_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] PC_RESET = 32'h8000_0000,
    localparam int               PTR_W    = $clog2(DEPTH)
) (
    input  logic              I_sys_clk,
    input  logic              I_rst,
    output logic              O_req_valid,
    output logic [ADDR_W-1:0] O_req_addr,
    input  logic              I_req_ready,
    input  logic              I_rsp_valid,
    input  logic [INST_W-1:0] I_rsp_inst,
    output logic              O_IF_valid,
    output logic [ADDR_W-1:0] O_pc,
    output logic [INST_W-1:0] O_inst,
    input  logic              I_IF_ID_allowin,
    input  logic              I_redirect,
    input  logic [ADDR_W-1:0] I_redirect_pc
`ifdef YSYX_22040750_IFU_PERF_EN
    ,
    output logic [63:0]       O_perf_fetch,
    output logic [63:0]       O_perf_stall,
    output logic [31:0]       O_perf_squash
`endif
);

    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_en;
    logic [CNT_W-1:0]  r_rd_ptr, r_wr_ptr, r_fill_ptr, r_drop_cnt;

    logic [CNT_W-1:0]  w_alloc, w_unfilled;
    logic [CNT_W:0]    w_inflight;
    logic [PTR_W-1:0]  w_rd_idx, w_wr_idx, w_fill_idx;
    logic              w_not_empty, w_req_fire, w_pop;
    logic              w_rsp_drop, w_rsp_fill, w_redir_absorb;
    logic [1:0]        w_unused_pc_lo;

    assign w_alloc     = r_wr_ptr - r_rd_ptr;
    assign w_unfilled  = r_wr_ptr - r_fill_ptr;
    assign w_inflight  = {1'b0, w_alloc} + {1'b0, r_drop_cnt};
    assign w_rd_idx    = r_rd_ptr[PTR_W-1:0];
    assign w_wr_idx    = r_wr_ptr[PTR_W-1:0];
    assign w_fill_idx  = r_fill_ptr[PTR_W-1:0];
    assign w_not_empty = (w_alloc != '0);

    // Squashed-but-outstanding responses still occupy memory-side slots, so they count against DEPTH.
    assign O_req_valid = r_en && (w_inflight < DEPTH_V) && !I_redirect;
    assign O_req_addr  = r_fetch_pc;
    assign O_IF_valid  = w_not_empty && r_filled[w_rd_idx] && !I_redirect;
    assign O_pc        = w_not_empty ? r_pc_mem[w_rd_idx]   : '0;
    assign O_inst      = w_not_empty ? r_inst_mem[w_rd_idx] : '0;

    assign w_req_fire     = O_req_valid && I_req_ready;
    assign w_pop          = O_IF_valid && I_IF_ID_allowin;
    assign w_rsp_drop     = I_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill     = I_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0) && !I_redirect;
    assign w_redir_absorb = I_rsp_valid && ((r_drop_cnt != '0) || (w_unfilled != '0));
    assign w_unused_pc_lo = I_redirect_pc[1:0];

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_fetch_pc <= PC_RESET;
            r_en       <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_drop_cnt <= '0;
            r_filled   <= '0;
        end else begin
            r_en <= 1'b1;
            if (I_redirect) begin
                // Unfilled entries become pending drops; a response arriving now consumes one.
                r_drop_cnt <= r_drop_cnt + w_unfilled - CNT_W'(w_redir_absorb);
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_fill_ptr <= '0;
                r_filled   <= '0;
                r_fetch_pc <= {I_redirect_pc[ADDR_W-1:2], 2'b00};
            end else begin
                if (w_req_fire) begin
                    r_wr_ptr             <= r_wr_ptr + CNT_W'(1);
                    r_fetch_pc           <= r_fetch_pc + ADDR_W'(4);
                    r_filled[w_wr_idx]   <= 1'b0;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_rsp_fill) begin
                    r_fill_ptr           <= r_fill_ptr + CNT_W'(1);
                    r_filled[w_fill_idx] <= 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr           <= r_rd_ptr + CNT_W'(1);
                    r_filled[w_rd_idx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_rst && w_req_fire) begin
            r_pc_mem[w_wr_idx] <= r_fetch_pc;
        end
        if (!I_rst && w_rsp_fill) begin
            r_inst_mem[w_fill_idx] <= I_rsp_inst;
        end
    end

    a_rsp_expected : assert property (@(posedge I_sys_clk) disable iff (I_rst)
        I_rsp_valid |-> ((r_drop_cnt != '0) || (w_unfilled != '0)));

`ifdef YSYX_22040750_IFU_PERF_EN
    logic w_squash;
    assign w_squash = I_redirect ? w_redir_absorb : w_rsp_drop;

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            O_perf_fetch  <= '0;
            O_perf_stall  <= '0;
            O_perf_squash <= '0;
        end else begin
            if (w_req_fire) begin
                O_perf_fetch <= O_perf_fetch + 64'd1;
            end
            if (r_en && !O_IF_valid && I_IF_ID_allowin) begin
                O_perf_stall <= O_perf_stall + 64'd1;
            end
            if (w_squash) begin
                O_perf_squash <= O_perf_squash + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040750_ifu_queue.sv
// Directed bench for ysyx_22040750_ifu_queue: in-order memory model plus a queue-level reference
// checked every cycle, and literal expectations at the interesting points.
module tb_ysyx_22040750_ifu_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;

    logic        clk;
    logic        rst, req_valid, req_ready, rsp_valid, if_valid, allowin, redirect;
    logic [31:0] req_addr, rsp_inst, pc, inst, redirect_pc;
    bit          mem_hold;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_22040750_ifu_queue dut (
        .I_sys_clk      (clk),
        .I_rst          (rst),
        .O_req_valid    (req_valid),
        .O_req_addr     (req_addr),
        .I_req_ready    (req_ready),
        .I_rsp_valid    (rsp_valid),
        .I_rsp_inst     (rsp_inst),
        .O_IF_valid     (if_valid),
        .O_pc           (pc),
        .O_inst         (inst),
        .I_IF_ID_allowin(allowin),
        .I_redirect     (redirect),
        .I_redirect_pc  (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory holds accepted fetch addresses in order; the instruction for address a is ~a.
    logic [31:0] mem_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    ent_t        mq[$];
    int          m_drop;
    logic [31:0] m_pc;
    bit          m_en;
    bit          m_live = 0;

    always @(negedge clk) begin : model
        bit ev, eif;
        int unf;
        ev  = m_en && (mq.size() + m_drop < DEPTH) && !redirect;
        eif = (mq.size() > 0) && mq[0].filled && !redirect;
        if (m_live) begin
            check("mdl_req_valid", req_valid, ev);
            check("mdl_req_addr", req_addr, m_pc);
            check("mdl_if_valid", if_valid, eif);
            check("mdl_pc", pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
            if (eif) check("mdl_inst", inst, mq[0].inst);
        end
        if (req_valid && req_ready && !rst) mem_q.push_back(req_addr);
        if (rst) begin
            mq.delete();
            mem_q.delete();
            m_drop = 0;
            m_pc   = PC_RESET;
            m_en   = 0;
            m_live = 1;
        end else if (redirect) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = m_drop + unf;
            if (rsp_valid && m_drop > 0) m_drop--;
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            m_en = 1;
        end else begin
            if (rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].filled = 1;
                            mq[i].inst   = rsp_inst;
                            break;
                        end
                    end
                end
            end
            if (eif && allowin) void'(mq.pop_front());
            if (ev && req_ready) begin
                mq.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            m_en = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst || mem_hold || mem_q.size() == 0) begin
            rsp_valid = 1'b0;
            rsp_inst  = '0;
        end else begin
            rsp_valid = 1'b1;
            rsp_inst  = ~mem_q.pop_front();
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_head(input string name, input logic [31:0] epc, input logic [31:0] einst);
        int k;
        k = 0;
        while (!if_valid && k < 20) begin
            tick();
            settle();
            k++;
        end
        if (!if_valid) begin
            n_total++;
            $display("FAIL %s: O_IF_valid never rose, expected pc %h", name, epc);
        end else begin
            check({name, "_pc"}, pc, epc);
            check({name, "_inst"}, inst, einst);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int hs;
        rst = 1; req_ready = 0; allowin = 0; redirect = 0; redirect_pc = '0;
        rsp_valid = 0; rsp_inst = '0; mem_hold = 0;

        // Reset state, then streaming with single-cycle memory
        tick(); tick(); settle();
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr", req_addr, 32'h8000_0000);
        rst = 0; req_ready = 1; allowin = 1;
        settle();
        check("en_delay", req_valid, 1'b0);
        tick(); settle();
        check("first_req_valid", req_valid, 1'b1);
        check("first_addr", req_addr, 32'h8000_0000);
        tick(); settle();
        check("second_addr", req_addr, 32'h8000_0004);
        check("no_early_if", if_valid, 1'b0);
        tick(); settle();
        check("first_if_valid", if_valid, 1'b1);
        check("first_pc", pc, 32'h8000_0000);
        check("first_inst", inst, 32'h7FFF_FFFF);
        repeat (8) tick();

        // allowin low: exactly DEPTH requests, head stays put, then one pop per cycle
        rst = 1; tick();
        rst = 0; allowin = 0; req_ready = 1;
        hs = 0;
        repeat (10) begin
            tick(); settle();
            if (req_valid && req_ready) hs++;
        end
        check("full_req_count", 32'(hs), 32'd4);
        check("full_req_valid", req_valid, 1'b0);
        check("full_head_pc", pc, 32'h8000_0000);
        check("full_head_inst", inst, 32'h7FFF_FFFF);
        allowin = 1;
        tick(); settle();
        check("pop1_pc", pc, 32'h8000_0004);
        check("pop1_valid", if_valid, 1'b1);
        tick(); settle();
        check("pop2_pc", pc, 32'h8000_0008);
        repeat (6) tick();

        // Three unfilled in flight, then redirect to a misaligned target
        rst = 1; tick();
        rst = 0; mem_hold = 1; req_ready = 1; allowin = 1;
        tick(); tick(); tick();
        tick();
        req_ready = 0; redirect = 1; redirect_pc = 32'h8000_1002;
        settle();
        check("redir_req_valid", req_valid, 1'b0);
        mem_hold = 0;
        tick();
        redirect = 0; req_ready = 1;
        settle();
        check("redir_addr", req_addr, 32'h8000_1000);
        check("redir_req_after", req_valid, 1'b1);
        wait_head("redir_head", 32'h8000_1000, 32'h7FFF_EFFF);
        repeat (4) tick();

        // Redirect in the same cycle a response lands, head filled, two unfilled
        rst = 1; tick();
        rst = 0; mem_hold = 1; req_ready = 1; allowin = 1;
        tick();
        tick();
        mem_hold = 0;
        tick();
        tick();
        redirect = 1; redirect_pc = 32'h0000_0100;
        settle();
        check("redir_masks_if", if_valid, 1'b0);
        check("redir_head_pc", pc, 32'h8000_0000);
        tick();
        redirect = 0;
        settle();
        wait_head("drop_one_head", 32'h0000_0100, 32'hFFFF_FEFF);
        repeat (4) tick();

        // Fetch address wraps to zero
        redirect = 1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 0;
        settle();
        check("wrap_addr0", req_addr, 32'hFFFF_FFF8);
        tick(); settle();
        check("wrap_addr1", req_addr, 32'hFFFF_FFFC);
        tick(); settle();
        check("wrap_addr2", req_addr, 32'h0000_0000);
        repeat (6) tick();

        // Reset with pending drops and occupied queue
        rst = 1; tick();
        rst = 0; mem_hold = 1; req_ready = 1; allowin = 0;
        tick(); tick();
        tick();
        redirect = 1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 0;
        tick(); tick();
        settle();
        check("drop_cap_req_valid", req_valid, 1'b0);
        rst = 1;
        tick(); settle();
        check("midrst_req_valid", req_valid, 1'b0);
        check("midrst_if_valid", if_valid, 1'b0);
        check("midrst_pc", pc, 32'h0);
        rst = 0; mem_hold = 0; allowin = 1;
        tick(); settle();
        check("restart_addr", req_addr, 32'h8000_0000);
        check("restart_req_valid", req_valid, 1'b1);
        wait_head("restart_head", 32'h8000_0000, 32'h7FFF_FFFF);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ysyx_22040750_ifu_queue.md
Name: ysyx_22040750_ifu_queue

Overview:
Parametrised instruction-fetch stage. Generates sequential fetch addresses and issues them on a valid/ready request channel, with several requests in flight. Buffers in-order responses with their PCs in a circular queue and presents them to IF/ID with a valid/allowin handshake. Supports redirect/flush from later stages, including squashing responses to requests already in flight.

Parameters:
ADDR_W, 32, PC / fetch-address width
INST_W, 32, instruction width
DEPTH, 4, queue entries (power of 2, >=2); also the maximum outstanding plus buffered fetches
PC_RESET, 32'h80000000, first fetch address after reset
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
I_sys_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
O_req_valid  out  1  fetch request valid
O_req_addr  out  ADDR_W  fetch address
I_req_ready  in  1  memory accepts request
I_rsp_valid  in  1  in-order instruction response
I_rsp_inst  in  INST_W  response data
O_IF_valid  out  1  head entry valid to IF/ID
O_pc  out  ADDR_W  PC of head entry
O_inst  out  INST_W  instruction of head entry
I_IF_ID_allowin  in  1  IF/ID accepts head entry
I_redirect  in  1  flush and restart fetch
I_redirect_pc  in  ADDR_W  restart address

Behaviour:
- Clock I_sys_clk; reset I_rst is synchronous and active-high. All state changes on the posedge.
- Reset values:
  - fetch_pc = PC_RESET; en = 0; rd/wr/fill pointers = 0; count = 0; drop_cnt = 0.
  - O_req_valid = 0, O_IF_valid = 0, O_pc = 0, O_inst = 0.
- en rises one cycle after reset deasserts.
- Queue entry = {pc, inst, filled}.
  - Allocate at wr_ptr on request handshake, storing pc.
  - Fill at fill_ptr on an accepted response.
  - Pop at rd_ptr.
  - alloc = wr_ptr - rd_ptr, with an extra wrap bit so full and empty are distinguished.
- O_req_valid = en && alloc + drop_cnt < DEPTH && !I_redirect. O_req_addr = fetch_pc.
- Request handshake (O_req_valid && I_req_ready): allocate; fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W.
- Response handling:
  - If drop_cnt > 0: discard, drop_cnt--.
  - Else: write inst at fill_ptr, set filled, fill_ptr++.
  - A response with no allocated unfilled entry and drop_cnt == 0 is a protocol error. Ignore it (assertion in sim).
- O_IF_valid = entry[rd_ptr].filled && alloc != 0 && !I_redirect. O_pc and O_inst come from entry[rd_ptr] combinationally; 0 when empty.
- Pop when O_IF_valid && I_IF_ID_allowin; clear filled, rd_ptr++.
- Latencies:
  - A response is visible on O_IF_valid the cycle after I_rsp_valid (registered queue).
  - Minimum request-to-output latency is 2 cycles.
- Simultaneous push, fill and pop in one cycle are all legal. A full queue holds head data stable until allowin.
- Redirect (highest priority), in the I_redirect cycle:
  - Accept no handshake on either side and perform no pop.
  - drop_cnt <= drop_cnt + (allocated unfilled entries) - (1 if a response is discarded this cycle).
  - rd_ptr = wr_ptr = fill_ptr <= 0; all filled cleared.
  - fetch_pc <= {I_redirect_pc[ADDR_W-1:2], 2'b00}.
  - Fetch resumes the next cycle.
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Reset mid-operation discards everything, including drop_cnt. The memory side is reset by the same I_rst.

Optional Feature:
- Macro: YSYX_22040750_IFU_PERF_EN.
- When defined, adds three outputs, all reset to 0 and wrapping:
  - O_perf_fetch (64-bit): request handshakes.
  - O_perf_stall (64-bit): cycles with en && !O_IF_valid && I_IF_ID_allowin.
  - O_perf_squash (32-bit): responses discarded via drop_cnt.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then I_req_ready=1 with responses one cycle after each request and allowin=1 → O_req_addr 0x80000000, 0x80000004, ... in order; first O_IF_valid 2 cycles after the first request; O_pc/O_inst pairs match.
- allowin=0 with DEPTH=4 → exactly 4 requests issued, then O_req_valid=0. Head stays pc 0x80000000 stable until allowin=1, then one pop per cycle.
- 3 requests in flight, unfilled, then I_redirect with pc 0x80001002 → next O_req_addr 0x80001000. The 3 late responses are discarded; the first O_IF_valid has O_pc 0x80001000.
- Redirect in the same cycle a response arrives with 2 unfilled → drop_cnt=1. O_IF_valid=0 during the redirect cycle even if the head was filled.
- fetch_pc 0xFFFFFFFC, request handshake → next address 0x00000000.
- I_rst asserted with full queue and drop_cnt=2 → next cycle O_IF_valid=0, O_req_valid=0; then fetch restarts at PC_RESET.
